// File: rtl/nr_recip_seed_stage.sv
// rtl/nr_recip_seed_stage.sv - normalise divisor and produce the linear Newton-Raphson reciprocal seed
module nr_recip_seed_stage #(
    parameter int WIDTH = 4,
    parameter int FRAC  = 8,
    parameter int SHW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    dividend,
    input  logic [WIDTH-1:0]    divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_dividend,
    output logic [WIDTH-1:0]    norm_divisor,
    output logic [SHW-1:0]      shift_amt,
    output logic [FRAC+1:0]     seed,
    output logic                div_by_zero
);

    localparam int PW   = FRAC + 2 + WIDTH;
    // round(48/17 * 2^FRAC) and round(32/17 * 2^FRAC) in integer arithmetic
    localparam int C1_I = (96 * (2 ** FRAC) + 17) / 34;
    localparam int C2_I = (64 * (2 ** FRAC) + 17) / 34;
    localparam logic [FRAC+1:0] C1 = (FRAC+2)'(C1_I);
    localparam logic [FRAC+1:0] C2 = (FRAC+2)'(C2_I);

    logic             v1, v2, v3;
    logic             r1, r2, r3;

    logic [WIDTH-1:0] s1_dividend, s1_divisor;
    logic [SHW-1:0]   s1_lzc;
    logic [WIDTH-1:0] s2_dividend, s2_dn;
    logic [SHW-1:0]   s2_lzc;
    logic             s2_dbz;

    logic [SHW-1:0]   lzc_c;
    logic             found_c;
    logic [WIDTH-1:0] dn_c;
    logic             dbz_c;
    logic [PW-1:0]    prod_c;
    logic [FRAC+1:0]  seed_c;

    // Each stage may load when empty or when its occupant leaves this cycle
    assign r3       = !v3 || out_ready;
    assign r2       = !v2 || r3;
    assign r1       = !v1 || r2;
    assign in_ready = r1;

    always_comb begin
        lzc_c   = '0;
        found_c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found_c) begin
                if (divisor[i]) begin
                    found_c = 1'b1;
                end else begin
                    lzc_c = lzc_c + 1'b1;
                end
            end
        end
        if (!found_c) begin
            lzc_c = '0;
        end
    end

    assign dn_c   = s1_divisor << s1_lzc;
    assign dbz_c  = (s1_divisor == '0);
    assign prod_c = PW'(s2_dn) * PW'(C2);
    assign seed_c = C1 - (FRAC+2)'(prod_c >> WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            s1_dividend <= '0;
            s1_divisor  <= '0;
            s1_lzc      <= '0;
        end else if (r1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_dividend <= dividend;
                s1_divisor  <= divisor;
                s1_lzc      <= lzc_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2          <= 1'b0;
            s2_dividend <= '0;
            s2_dn       <= '0;
            s2_lzc      <= '0;
            s2_dbz      <= 1'b0;
        end else if (r2) begin
            v2 <= v1;
            if (v1) begin
                s2_dividend <= s1_dividend;
                s2_dn       <= dn_c;
                s2_lzc      <= s1_lzc;
                s2_dbz      <= dbz_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3           <= 1'b0;
            out_dividend <= '0;
            norm_divisor <= '0;
            shift_amt    <= '0;
            seed         <= '0;
            div_by_zero  <= 1'b0;
        end else if (r3) begin
            v3 <= v2;
            if (v2) begin
                out_dividend <= s2_dividend;
                norm_divisor <= s2_dbz ? '0 : s2_dn;
                shift_amt    <= s2_dbz ? '0 : s2_lzc;
                seed         <= s2_dbz ? '0 : seed_c;
                div_by_zero  <= s2_dbz;
            end
        end
    end

    assign out_valid = v3;

endmodule

// File: tb/tb_nr_recip_seed_stage.sv
// tb/tb_nr_recip_seed_stage.sv - directed table-driven bench for nr_recip_seed_stage
module tb_nr_recip_seed_stage;

    localparam int WIDTH = 4;
    localparam int FRAC  = 8;
    localparam int SHW   = 2;
    localparam int NV    = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_dividend;
    logic [WIDTH-1:0] norm_divisor;
    logic [SHW-1:0]   shift_amt;
    logic [FRAC+1:0]  seed;
    logic             div_by_zero;

    always #5 clk = ~clk;

    nr_recip_seed_stage #(.WIDTH(WIDTH), .FRAC(FRAC), .SHW(SHW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dividend     (dividend),
        .divisor      (divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dividend (out_dividend),
        .norm_divisor (norm_divisor),
        .shift_amt    (shift_amt),
        .seed         (seed),
        .div_by_zero  (div_by_zero)
    );

    typedef struct {
        logic [WIDTH-1:0] dvd;
        logic [WIDTH-1:0] dvs;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] dn;
        logic [FRAC+1:0]  sd;
        logic             dbz;
    } vec_t;

    vec_t tv[NV];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int i);
        chk({tag, " out_dividend"}, 32'(out_dividend), 32'(tv[i].dvd));
        chk({tag, " norm_divisor"}, 32'(norm_divisor), 32'(tv[i].dn));
        chk({tag, " shift_amt"},    32'(shift_amt),    32'(tv[i].sh));
        chk({tag, " seed"},         32'(seed),         32'(tv[i].sd));
        chk({tag, " div_by_zero"},  32'(div_by_zero),  32'(tv[i].dbz));
    endtask

    task automatic run_single(input int i);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        chk($sformatf("v%0d in_ready idle", i), 32'(in_ready), 32'd1);
        dividend = tv[i].dvd;
        divisor  = tv[i].dvs;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", i), 32'(lat), 32'd3);
        check_out($sformatf("v%0d", i), i);
    endtask

    task automatic run_stream(input string tag, input int n, input int stall_until);
        int   q[$];
        int   sent = 0;
        int   rcv = 0;
        int   cyc = 0;
        int   first = -1;
        int   last = -1;
        int   extra = 0;
        logic held = 1'b0;
        logic [31:0] snap = '0;
        logic [31:0] now;
        while ((sent < n || rcv < n) && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc >= stall_until);
            if (sent < n) begin
                in_valid = 1'b1;
                dividend = tv[sent % NV].dvd;
                divisor  = tv[sent % NV].dvs;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            now = 32'({out_valid, out_dividend, norm_divisor, shift_amt, seed, div_by_zero});
            if (held) chk({tag, " held stable"}, now, snap);
            if (stall_until > 0 && cyc == stall_until - 1) begin
                chk({tag, " accepts before full"}, 32'(sent), 32'd3);
                chk({tag, " in_ready full"}, 32'(in_ready), 32'd0);
            end
            if (stall_until > 0 && cyc == stall_until)
                chk({tag, " in_ready on release"}, 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk({tag, " spurious output"}, 32'd1, 32'd0);
                end else begin
                    check_out($sformatf("%s item%0d", tag, rcv), q.pop_front());
                end
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
            held = out_valid && !out_ready;
            snap = now;
            if (in_valid && in_ready) begin
                q.push_back(sent % NV);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk({tag, " received count"}, 32'(rcv), 32'(n));
        if (stall_until == 0) chk({tag, " consecutive"}, 32'(last - first), 32'(n - 1));
        for (int k = 0; k < 4; k++) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        chk({tag, " no duplicate"}, 32'(extra), 32'd0);
    endtask

    initial begin
        tv[0] = '{4'd5,  4'd2,  2'd2, 4'd8,  10'd482, 1'b0};
        tv[1] = '{4'd7,  4'd5,  2'd1, 4'd10, 10'd422, 1'b0};
        tv[2] = '{4'd12, 4'd15, 2'd0, 4'd15, 10'd272, 1'b0};
        tv[3] = '{4'd0,  4'd1,  2'd3, 4'd8,  10'd482, 1'b0};
        tv[4] = '{4'd1,  4'd0,  2'd0, 4'd0,  10'd0,   1'b1};
        tv[5] = '{4'd15, 4'd3,  2'd2, 4'd12, 10'd362, 1'b0};
        tv[6] = '{4'd9,  4'd4,  2'd1, 4'd8,  10'd482, 1'b0};
        tv[7] = '{4'd6,  4'd9,  2'd0, 4'd9,  10'd452, 1'b0};
        tv[8] = '{4'd10, 4'd7,  2'd1, 4'd14, 10'd302, 1'b0};
        tv[9] = '{4'd4,  4'd6,  2'd1, 4'd12, 10'd362, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset data", 32'({out_dividend, norm_divisor, shift_amt, seed, div_by_zero}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_single(i);

        run_stream("stream", 8, 0);
        run_stream("stall", 7, 6);

        // two transactions in flight, the older one already presented at the output
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = tv[1].dvd;
        divisor   = tv[1].dvs;
        @(negedge clk);
        dividend  = tv[2].dvd;
        divisor   = tv[2].dvs;
        @(negedge clk);
        in_valid  = 1'b0;
        @(negedge clk);
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset in_ready", 32'(in_ready), 32'd1);
        chk("async reset data", 32'({out_dividend, seed}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        begin
            int stale = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (out_valid) stale++;
            end
            chk("no stale after reset", 32'(stale), 32'd0);
        end

        run_single(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
